// File: rtl/freq_counter_scan_if.sv
// Measurement/display bundle for freq_counter_scan.
// The input pin and hold switch travel in; the result and display scan travel out.
interface freq_counter_scan_if #(
  parameter int COUNT_W = 32,
  parameter int DIGITS  = 8
) ();
  logic               signal_in;
  logic               hold;
  logic [COUNT_W-1:0] freq_value;
  logic               freq_valid;
  logic               overflow;
  logic [DIGITS-1:0]  digit;
  logic [7:0]         segment;

  modport slave (
    input  signal_in, hold,
    output freq_value, freq_valid, overflow,
    output digit, segment
  );

  modport master (
    output signal_in, hold,
    input  freq_value, freq_valid, overflow,
    input  digit, segment
  );
endinterface

// File: rtl/freq_counter_scan.sv
// Gated edge counter with a serial double-dabble converter.
// It drives a multiplexed common-anode seven-segment display.
module freq_counter_scan #(
  parameter int GATE_CYCLES = 2500,
  parameter int COUNT_W     = 32,
  parameter int DIGITS      = 8,
  parameter int SCAN_CYCLES = 5000
) (
  input logic            clock,
  input logic            reset_n,
  freq_counter_scan_if.slave io
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int BW = $clog2(COUNT_W);
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NB = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} st_t;

  logic [2:0]         sync_q;
  logic               rise;
  logic [GW-1:0]      gate_q;
  logic [COUNT_W-1:0] cnt_q, cnt_inc, freq_q;
  logic               sat_q, sat_inc, ovf_q, valid_q;

  st_t                state_q, state_d;
  logic [COUNT_W-1:0] sh_q, sh_d;
  logic [NB-1:0]      bcd_q, bcd_d, adj;
  logic [NB-1:0]      disp_q, disp_d;
  logic [BW-1:0]      bc_q, bc_d;
  logic               bovf_q, bovf_d, dovf_q, dovf_d;

  logic [SW-1:0]      scan_q, scan_d;
  logic [DW-1:0]      idx_q, idx_d;
  logic [DIGITS-1:0]  dig_q, dig_d, keep;
  logic [7:0]         seg_q, seg_d;
  logic               any_nz;

  function automatic logic [NB-1:0] add3(input logic [NB-1:0] b);
    logic [NB-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign rise    = sync_q[1] & ~sync_q[2];
  assign cnt_inc = (rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign sat_inc = sat_q | (rise & (&cnt_q));
  assign adj     = add3(bcd_q);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    bc_d    = bc_q;
    bovf_d  = bovf_q;
    disp_d  = disp_q;
    dovf_d  = dovf_q;
    unique case (state_q)
      IDLE: if (valid_q) state_d = LOAD;
      LOAD: begin
        sh_d    = freq_q;
        bcd_d   = '0;
        bc_d    = '0;
        bovf_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d  = {adj[NB-2:0], sh_q[COUNT_W-1]};
        sh_d   = {sh_q[COUNT_W-2:0], 1'b0};
        bovf_d = bovf_q | adj[NB-1];
        bc_d   = bc_q + 1'b1;
        if (bc_q == BW'(COUNT_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        if (!io.hold) begin
          disp_d = bcd_q;
          dovf_d = bovf_q | ovf_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Segment is registered from the digit index that is lit next cycle.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    dig_d  = dig_q;
    if (scan_q == SW'(SCAN_CYCLES - 1)) begin
      scan_d = '0;
      dig_d  = (dig_q << 1) | (dig_q >> (DIGITS - 1));
      idx_d  = (idx_q == DW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    any_nz = 1'b0;
    keep   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz  = any_nz | (disp_q[4*i +: 4] != 4'd0);
      keep[i] = any_nz | (i == 0);
    end
    if (dovf_q)
      seg_d = 8'hBF;
    else if (keep[idx_d])
      seg_d = seg7(disp_q[4*idx_d +: 4]);
    else
      seg_d = 8'hFF;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      gate_q  <= GW'(GATE_CYCLES - 1);
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      bc_q    <= '0;
      bovf_q  <= 1'b0;
      disp_q  <= '0;
      dovf_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      dig_q   <= DIGITS'(1);
      seg_q   <= 8'hC0;
    end else begin
      sync_q  <= {sync_q[1:0], io.signal_in};
      valid_q <= 1'b0;
      if (gate_q == '0) begin
        gate_q  <= GW'(GATE_CYCLES - 1);
        freq_q  <= cnt_inc;
        ovf_q   <= sat_inc;
        valid_q <= 1'b1;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
      end else begin
        gate_q <= gate_q - 1'b1;
        cnt_q  <= cnt_inc;
        sat_q  <= sat_inc;
      end
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      bc_q    <= bc_d;
      bovf_q  <= bovf_d;
      disp_q  <= disp_d;
      dovf_q  <= dovf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
    end
  end

  assign io.freq_value = freq_q;
  assign io.freq_valid = valid_q;
  assign io.overflow   = ovf_q;
  assign io.digit      = dig_q;
  assign io.segment    = seg_q;
endmodule

// File: doc/freq_counter_scan.md
Name: freq_counter_scan

Overview:
- Parametrised reciprocal-free frequency counter with an integrated multiplexed seven-segment driver.
- Counts rising edges of an asynchronous input over a programmable gate window and latches the result.
- Converts the result to BCD with a sequential double-dabble engine and scans it onto DIGITS common-anode digits.
- Sits between the board input pin and the board display as a standalone measurement/display block.

Parameters:
GATE_CYCLES, 2500, clock cycles per measurement window; must be > COUNT_W+4
COUNT_W, 32, edge counter / result width
DIGITS, 8, number of displayed decimal digits (1..10)
SCAN_CYCLES, 5000, clock cycles each digit stays lit

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
signal_in  in  1  asynchronous signal under measurement
hold  in  1  1 = freeze display contents; measurement continues
freq_value  out  COUNT_W  last latched edge count (edges per window)
freq_valid  out  1  one-cycle pulse when freq_value updates
overflow  out  1  sticky per window: edge counter saturated in last latched window
digit  out  DIGITS  one-hot active-high digit enable, bit 0 = least significant digit
segment  out  8  active-low {dp,g,f,e,d,c,b,a}

Behaviour:
Reset (reset_n low, async): freq_value=0, freq_valid=0, overflow=0, digit=1 (bit 0), segment=8'hC0 ("0"), display register=all zero, counters/FSM to zero/IDLE.
Input path: 2-FF synchroniser, third flop for edge detect; edge = sync & ~prev. Edge-to-count latency 3 cycles.
Gate:
- gate_cnt counts GATE_CYCLES-1 down to 0.
- At 0: freq_value <= edge_cnt (+1 if an edge in that cycle, saturating); overflow <= sat flag; freq_valid=1 next cycle; edge_cnt and sat flag cleared; gate_cnt reloaded.
- No edge is lost or double counted across the boundary.
- edge_cnt saturates at 2^COUNT_W-1 and sets the sat flag; no wrap.
BCD FSM:
- States: IDLE -> LOAD -> SHIFT (COUNT_W cycles) -> COMMIT -> IDLE.
- LOAD on freq_valid: copy freq_value into shift register, clear BCD register (4*DIGITS bits).
- SHIFT: add-3 to every BCD nibble >=5, then shift left one bit. Any 1 shifted out of the top nibble sets bcd_ovf.
- COMMIT: if hold=0, display register <= BCD result, disp_ovf <= bcd_ovf|overflow. If hold=1, display unchanged.
- Total conversion latency COUNT_W+2 cycles after freq_valid.
- A freq_valid arriving outside IDLE is a parameter violation (guaranteed by the GATE_CYCLES constraint); the bench asserts it never occurs.
Scan:
- scan_cnt counts 0..SCAN_CYCLES-1. At terminal: digit rotates left (MSB wraps to bit 0), digit index increments mod DIGITS, scan_cnt=0.
- Segment output is registered, aligned with digit (same cycle).
- Decode 0-9 standard, dp always off (bit7=1).
- Leading-zero blanking: digits above the most significant nonzero digit show 8'hFF. Digit 0 is never blanked.
- disp_ovf=1: every digit shows "-" (8'hBF).
hold: sampled only at COMMIT; freq_value/freq_valid/overflow still update.
Reset mid-operation: all state aborted immediately; the first window after release is a full GATE_CYCLES.

Test Plan:
- Reset then idle, signal_in=0 -> after 2500 cycles freq_valid pulse, freq_value=0; after 34 more cycles display digit0=8'hC0, digits1-7=8'hFF.
- Square wave period 10 clocks, GATE_CYCLES=2500 -> freq_value=250 each window ±0; display digits 2,1,0 = "2","5","0" (8'hA4,8'h92,8'hC0), rest blank.
- Edge placed exactly on the gate-terminal cycle across 3 windows -> sum of freq_value over the windows equals total edges injected; no edge lost or duplicated.
- COUNT_W=8, period 2 clocks -> edge_cnt saturates at 255, overflow=1, all digits 8'hBF; next window with 100 edges -> overflow=0, display "100".
- DIGITS=2, 150 edges/window -> bcd_ovf, all digits "-"; hold=1 while the input changes to 40 edges -> freq_value=40 but display frozen until hold=0, then "40".
- SCAN_CYCLES=4, DIGITS=8 -> digit sequence 01,02,04,...,80,01 every 4 cycles; reset_n pulsed mid-scan -> digit=01, segment=8'hC0 within the same cycle (async).
